timer_display_mux: RTL and testbench
====================================

Name: timer_display_mux

Overview:
Multi-digit BCD seconds timer with time-multiplexed 7-segment output. It is the next generation of the single-digit interval timer display, generalised to N BCD digits. It adds preset load, start/pause control, up/down terminal detection and digit scanning. It sits between game control (preset/start/stop) and the board display, and its timeout pulse feeds the round-end logic.

Parameters:
CLOCK_FREQ, 50_000, clk cycles per counted second (>=2)
N_DIGITS, 2, number of BCD digits displayed/counted (1..4)
SCAN_DIV, 50, clk cycles each digit is driven before advancing (>=1)
BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 never blanked); 0 = show all digits

Ports:
clk  in  1  master clock
rst  in  1  synchronous reset, active-high
load  in  1  latch preset/dir; force IDLE
preset  in  4*N_DIGITS  BCD target/start value, digit 0 in [3:0]
dir  in  1  1 = count up 0->preset, 0 = count down preset->0; sampled only on load
start  in  1  level/pulse; IDLE -> RUN
stop  in  1  level/pulse; RUN -> IDLE (pause)
count_bcd  out  4*N_DIGITS  current count, BCD
running  out  1  1 while in RUN
timeout  out  1  one-cycle pulse on reaching terminal count
seg  out  7  segments {a,b,c,d,e,f,g}, active-high, seg[6]=a
an  out  N_DIGITS  one-hot digit enable, active-high, an[0] = least significant digit

Behaviour:
- Single clock domain. Reset is synchronous and active-high on port rst; clock port is clk.
- Reset values: count_bcd=0, target=0, dir_q=0, state=IDLE, prescaler=0, running=0, timeout=0, scan index=0, an=one-hot bit 0, seg=7'b1111110 (digit "0").
- Terminal value T: dir_q=0 -> 0; dir_q=1 -> target.
- States: IDLE, RUN, DONE. All outputs are registered.
- Priority each cycle: rst > load > stop > start > tick.
- load (any state): target <= preset with each digit >9 clamped to 9. dir_q <= dir. count <= (dir ? 0 : clamped preset). prescaler <= 0. state <= IDLE.
- start in IDLE, count != T: state <= RUN. Prescaler resumes from its held value.
- start in IDLE, count == T: state <= DONE and timeout=1 on the same edge, with no counting.
- start in RUN or DONE: ignored. Leaving DONE requires load.
- stop in RUN: state <= IDLE, prescaler held (pause/resume). stop wins over start in the same cycle. stop in IDLE/DONE: no effect.
- Prescaler: counts only in RUN, 0..CLOCK_FREQ-1. Tick is the cycle it equals CLOCK_FREQ-1; it wraps to 0 on that edge.
- On a tick, count steps by ±1 in BCD. Digit carry/borrow: 9->0 carry up, 0->9 borrow down.
- On the same edge as the tick, if the new count == T: state <= DONE and timeout=1 for exactly one cycle.
- First step occurs CLOCK_FREQ cycles after RUN entry from prescaler=0.
- No wrap past the terminal count is possible. Up mode with target=0 hits the terminal count immediately on start.
- DONE: count held, running=0, timeout=0 after its pulse cycle.
- running = (state==RUN), registered alongside state.
- Scan: the scan counter is free-running, independent of state, 0..SCAN_DIV-1. On wrap, the digit index advances modulo N_DIGITS.
- an and seg update on the same edge, so seg always matches the digit selected by an.
- Blanking: when BLANK_LZ=1, digit k>0 is blanked (seg=0, an still asserted) if it and all higher digits are zero.
- Decoder: standard hex-style 0-9 patterns. Digit values never exceed 9 internally.

Test Plan:
- Bench uses CLOCK_FREQ=10, N_DIGITS=2, SCAN_DIV=4.
- Reset, then load preset=8'h12, dir=0, then start -> count_bcd steps 12,11,10,09 every 10 cycles. After 120 cycles from start, count=00 with a single-cycle timeout, running=0.
- Load preset=8'h10, dir=1, then start -> 00..09 then 10; timeout fires on the 10th tick; state DONE. A further start produces no timeout and no count change.
- During down count, pulse stop 3 cycles into a second, hold 20 cycles, then start -> next step arrives 7 cycles after restart. start+stop in the same cycle leaves the timer paused.
- Load preset=8'h0F -> target clamped to 8'h09. Load preset=0, dir=0, then start -> timeout the next edge, no ticks.
- Scan check: an alternates 01/10 every 4 cycles. With count=05, digit 1 is blanked (seg=0) and digit 0 shows 7'b1011011. With BLANK_LZ=0, digit 1 shows 7'b1111110.
- Assert load mid-run, and separately rst mid-run -> IDLE, prescaler=0, count reloaded / all reset values, no timeout pulse.

Source files
------------

// File: rtl/timer_display_mux.sv
// ============================================================================
// Module   : timer_display_mux
// Purpose  : N-digit BCD seconds timer (up/down, preset, pause) with a
//            time-multiplexed, leading-zero-blanked 7-segment display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_display_mux #(
    parameter int CLOCK_FREQ = 50_000,
    parameter int N_DIGITS   = 2,
    parameter int SCAN_DIV   = 50,
    parameter int BLANK_LZ   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   preset,
    input  logic                    dir,
    input  logic                    start,
    input  logic                    stop,
    output logic [4*N_DIGITS-1:0]   count_bcd,
    output logic                    running,
    output logic                    timeout,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an
);

    localparam int c_CW  = 4 * N_DIGITS;
    localparam int c_PW  = $clog2(CLOCK_FREQ);
    localparam int c_SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [6:0] c_SEG_ZERO = 7'b1111110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_count;
    logic [c_CW-1:0]   r_target;
    logic              r_dir;
    logic [c_PW-1:0]   r_presc;
    logic              r_running;
    logic              r_timeout;
    logic [c_SW-1:0]   r_scan;
    logic [c_IW-1:0]   r_idx;
    logic [N_DIGITS-1:0] r_an;
    logic [6:0]        r_seg;

    logic [c_CW-1:0]   w_preset_clamped;
    logic [c_CW-1:0]   w_count_inc;
    logic [c_CW-1:0]   w_count_dec;
    logic [c_CW-1:0]   w_next_count;
    logic [c_CW-1:0]   w_terminal;
    logic              w_tick;
    logic              w_scan_wrap;
    logic [c_IW-1:0]   w_idx_next;
    logic [3:0]        w_digit;
    logic              w_upper_zero;
    logic              w_blank;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // BCD clamp, increment and decrement, rippling carry/borrow digit by digit
    always_comb begin
        logic v_carry;
        logic v_borrow;
        w_preset_clamped = preset;
        w_count_inc      = r_count;
        w_count_dec      = r_count;
        v_carry          = 1'b1;
        v_borrow         = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (preset[4*k +: 4] > 4'd9) begin
                w_preset_clamped[4*k +: 4] = 4'd9;
            end
            if (v_carry) begin
                if (r_count[4*k +: 4] >= 4'd9) begin
                    w_count_inc[4*k +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*k +: 4] = r_count[4*k +: 4] + 4'd1;
                    v_carry = 1'b0;
                end
            end
            if (v_borrow) begin
                if (r_count[4*k +: 4] == 4'd0) begin
                    w_count_dec[4*k +: 4] = 4'd9;
                end else begin
                    w_count_dec[4*k +: 4] = r_count[4*k +: 4] - 4'd1;
                    v_borrow = 1'b0;
                end
            end
        end
    end

    assign w_terminal   = r_dir ? r_target : '0;
    assign w_next_count = r_dir ? w_count_inc : w_count_dec;
    assign w_tick       = (r_state == S_RUN) && (r_presc == c_PW'(CLOCK_FREQ - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_target  <= '0;
            r_dir     <= 1'b0;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (load) begin
                r_target  <= w_preset_clamped;
                r_dir     <= dir;
                r_count   <= dir ? '0 : w_preset_clamped;
                r_presc   <= '0;
                r_state   <= S_IDLE;
                r_running <= 1'b0;
            end else if (stop) begin
                // Asserted stop also masks a simultaneous start
                if (r_state == S_RUN) begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                end
            end else if (start && (r_state == S_IDLE)) begin
                if (r_count == w_terminal) begin
                    r_state   <= S_DONE;
                    r_timeout <= 1'b1;
                end else begin
                    r_state   <= S_RUN;
                    r_running <= 1'b1;
                end
            end else if (r_state == S_RUN) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_count <= w_next_count;
                    if (w_next_count == w_terminal) begin
                        r_state   <= S_DONE;
                        r_running <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end else begin
                    r_presc <= r_presc + c_PW'(1);
                end
            end
        end
    end

    assign w_scan_wrap = (r_scan == c_SW'(SCAN_DIV - 1));

    always_comb begin
        w_idx_next = r_idx;
        if (w_scan_wrap) begin
            w_idx_next = (r_idx == c_IW'(N_DIGITS - 1)) ? '0 : r_idx + c_IW'(1);
        end
    end

    // Select the digit to drive next and whether it is a leading zero
    always_comb begin
        w_digit      = 4'd0;
        w_upper_zero = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (w_idx_next == c_IW'(k)) begin
                w_digit = r_count[4*k +: 4];
            end
            if ((c_IW'(k) >= w_idx_next) && (r_count[4*k +: 4] != 4'd0)) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    assign w_blank = (BLANK_LZ != 0) && (w_idx_next != '0) && w_upper_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_an   <= N_DIGITS'(1);
            r_seg  <= c_SEG_ZERO;
        end else begin
            r_scan <= w_scan_wrap ? '0 : r_scan + c_SW'(1);
            r_idx  <= w_idx_next;
            r_an   <= N_DIGITS'(1) << w_idx_next;
            r_seg  <= w_blank ? 7'b0000000 : f_decode(w_digit);
        end
    end

    assign count_bcd = r_count;
    assign running   = r_running;
    assign timeout   = r_timeout;
    assign seg       = r_seg;
    assign an        = r_an;

endmodule

`default_nettype wire

// File: tb/tb_timer_display_mux.sv
// ============================================================================
// Module   : tb_timer_display_mux
// Purpose  : Directed self-checking bench for timer_display_mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_display_mux;

    localparam logic [6:0] c_SEG0 = 7'b1111110;
    localparam logic [6:0] c_SEG5 = 7'b1011011;

    logic        clk = 1'b0;
    logic        rst, load, dir, start, stop;
    logic [7:0]  preset;
    logic [7:0]  count_bcd, count_bcd2;
    logic        running, timeout, running2, timeout2;
    logic [6:0]  seg, seg2;
    logic [1:0]  an, an2;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    timer_display_mux #(.CLOCK_FREQ(10), .N_DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .load(load), .preset(preset), .dir(dir),
        .start(start), .stop(stop), .count_bcd(count_bcd), .running(running),
        .timeout(timeout), .seg(seg), .an(an)
    );

    timer_display_mux #(.CLOCK_FREQ(10), .N_DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .load(load), .preset(preset), .dir(dir),
        .start(start), .stop(stop), .count_bcd(count_bcd2), .running(running2),
        .timeout(timeout2), .seg(seg2), .an(an2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] p, input logic d);
        preset = p;
        dir    = d;
        load   = 1'b1;
        cyc(1);
        load   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        int trans;
        logic [1:0] prev_an;
        rst = 1'b1; load = 1'b0; dir = 1'b0; start = 1'b0; stop = 1'b0; preset = 8'h00;
        cyc(2);
        chk("rst_count",   32'(count_bcd), 32'h00);
        chk("rst_running", 32'(running),   0);
        chk("rst_timeout", 32'(timeout),   0);
        chk("rst_an",      32'(an),        32'h1);
        chk("rst_seg",     32'(seg),       32'(c_SEG0));
        chk("rst_nb_all",  {count_bcd2, 7'(0), running2, timeout2, an2, seg2},
                           {8'h00, 7'(0), 1'b0, 1'b0, 2'b01, c_SEG0});

        // Scan phase is deterministic from reset release
        rst = 1'b0;
        cyc(3);
        chk("scan_an_hold", 32'(an), 32'h1);
        cyc(1);
        chk("scan_an_adv",  32'(an), 32'h2);
        chk("scan_blank",   32'(seg), 32'h0);
        chk("scan_noblank", 32'(seg2), 32'(c_SEG0));

        // Down count 12 -> 00
        do_load(8'h12, 1'b0);
        chk("dn_load", 32'(count_bcd), 32'h12);
        do_start();
        chk("dn_run", 32'(running), 1);
        cyc(9);  chk("dn_pre_tick", 32'(count_bcd), 32'h12);
        cyc(1);  chk("dn_t1",  32'(count_bcd), 32'h11);
        cyc(10); chk("dn_t2",  32'(count_bcd), 32'h10);
        cyc(10); chk("dn_t3",  32'(count_bcd), 32'h09);
        cyc(89); chk("dn_119", {count_bcd, 6'(0), running, timeout}, {8'h01, 6'(0), 1'b1, 1'b0});
        cyc(1);  chk("dn_120", {count_bcd, 6'(0), running, timeout}, {8'h00, 6'(0), 1'b0, 1'b1});
        cyc(1);  chk("dn_121", {count_bcd, 6'(0), running, timeout}, {8'h00, 6'(0), 1'b0, 1'b0});

        // Pause / resume keeps the prescaler phase
        do_load(8'h12, 1'b0);
        do_start();
        cyc(10); chk("ps_t1", 32'(count_bcd), 32'h11);
        cyc(3);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("ps_stop", 32'(running), 0);
        cyc(20); chk("ps_hold", {count_bcd, 7'(0), running}, {8'h11, 7'(0), 1'b0});
        do_start();
        chk("ps_resume", 32'(running), 1);
        cyc(6); chk("ps_r6", 32'(count_bcd), 32'h11);
        cyc(1); chk("ps_r7", 32'(count_bcd), 32'h10);
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        chk("ps_both_run", 32'(running), 0);
        cyc(15); chk("ps_both_hold", 32'(count_bcd), 32'h10);
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        chk("ps_both_idle", 32'(running), 0);

        // Up count 00 -> 10
        do_load(8'h10, 1'b1);
        chk("up_load", 32'(count_bcd), 32'h00);
        do_start();
        cyc(90); chk("up_90",  {count_bcd, 7'(0), running}, {8'h09, 7'(0), 1'b1});
        cyc(9);  chk("up_99",  {count_bcd, 7'(0), timeout}, {8'h09, 7'(0), 1'b0});
        cyc(1);  chk("up_100", {count_bcd, 6'(0), running, timeout}, {8'h10, 6'(0), 1'b0, 1'b1});
        cyc(1);  chk("up_101", 32'(timeout), 0);
        do_start();
        chk("up_restart", {6'(0), running, timeout}, 8'h00);
        cyc(15); chk("up_held", 32'(count_bcd), 32'h10);

        // Digit clamping
        do_load(8'h0F, 1'b0); chk("clamp_0F", 32'(count_bcd), 32'h09);
        do_load(8'hA3, 1'b0); chk("clamp_A3", 32'(count_bcd), 32'h93);
        do_load(8'h0F, 1'b1);
        do_start();
        cyc(90); chk("clamp_up_tgt", {count_bcd, 7'(0), timeout}, {8'h09, 7'(0), 1'b1});

        // Already at terminal count
        do_load(8'h00, 1'b0);
        do_start();
        chk("zero_dn", {count_bcd, 6'(0), running, timeout}, {8'h00, 6'(0), 1'b0, 1'b1});
        cyc(1); chk("zero_dn_pulse", 32'(timeout), 0);
        do_load(8'h00, 1'b1);
        do_start();
        chk("zero_up", {6'(0), running, timeout}, 8'h01);

        // Scan with count 05
        do_load(8'h05, 1'b0);
        cyc(2);
        prev_an = an;
        trans   = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            if (an != prev_an) trans++;
            prev_an = an;
            if (an == 2'b01) begin
                chk("scan_d0",    32'(seg),  32'(c_SEG5));
                chk("scan_d0_nb", 32'(seg2), 32'(c_SEG5));
            end else begin
                chk("scan_d1_an", 32'(an),   32'h2);
                chk("scan_d1",    32'(seg),  32'h0);
                chk("scan_d1_nb", 32'(seg2), 32'(c_SEG0));
            end
        end
        chk("scan_period", 32'(trans), 2);

        // load mid-run
        do_load(8'h12, 1'b0);
        do_start();
        cyc(15); chk("ml_run", 32'(count_bcd), 32'h11);
        do_load(8'h34, 1'b0);
        chk("ml_load", {count_bcd, 6'(0), running, timeout}, {8'h34, 6'(0), 1'b0, 1'b0});
        do_start();
        cyc(9); chk("ml_r9",  32'(count_bcd), 32'h34);
        cyc(1); chk("ml_r10", 32'(count_bcd), 32'h33);

        // rst mid-run
        cyc(3);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("mr_state", {count_bcd, 6'(0), running, timeout}, {8'h00, 6'(0), 1'b0, 1'b0});
        chk("mr_disp",  {an, seg}, {2'b01, c_SEG0});
        do_start();
        chk("mr_start", {6'(0), running, timeout}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
